// File: rtl/fetch_queue.sv
// Instruction fetch/prefetch stage: issues sequential word fetches, buffers
// in-order responses in a small FIFO and hands {pc, instruction} to decode.
// A redirect flushes the FIFO and drops responses still in flight.
module fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clock,
   input  logic        reset,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [CW-1:0] count;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [31:0]   data_mem [DEPTH];
   logic [31:0]   pc_mem   [DEPTH];

   logic          req_fire;
   logic          push;
   logic          pop;
   logic [CW:0]   occupancy;
   logic [31:0]   redirect_target;

   // Request gating, handshakes and head-of-queue presentation
   always_comb begin
      occupancy       = {1'b0, count} + {1'b0, outstanding};
      redirect_target = redirect_pc & ~32'h0000_0003;
      mem_req_valid   = !reset && !redirect_valid && (occupancy < DEPTH_C);
      mem_req_addr    = fetch_pc;
      req_fire        = mem_req_valid && mem_req_ready;
      inst_valid      = (count != '0);
      inst_data       = data_mem[rd_ptr];
      inst_pc         = pc_mem[rd_ptr];
      // In-flight entries issued before a redirect are counted off by discard
      push            = mem_resp_valid && !redirect_valid && (discard == '0);
      pop             = inst_valid && inst_ready && !redirect_valid;
   end

   // Fetch pointer, in-flight bookkeeping and FIFO storage
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         discard     <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_mem[i] <= '0;
            pc_mem[i]   <= '0;
         end
      end else if (redirect_valid) begin
         fetch_pc    <= redirect_target;
         resp_pc     <= redirect_target;
         count       <= '0;
         rd_ptr      <= wr_ptr;
         // A response landing this cycle is dropped and retires one in-flight slot
         outstanding <= outstanding - CW'(mem_resp_valid);
         discard     <= outstanding - CW'(mem_resp_valid);
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         outstanding <= outstanding + CW'(req_fire) - CW'(mem_resp_valid);
         if (mem_resp_valid && (discard != '0)) begin
            discard <= discard - CW'(1);
         end
         if (push) begin
            data_mem[wr_ptr] <= mem_resp_data;
            pc_mem[wr_ptr]   <= resp_pc;
            wr_ptr           <= wr_ptr + AW'(1);
            resp_pc          <= resp_pc + 32'd4;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Memory must only answer fetches that were actually issued
   resp_has_owner: assert property (@(posedge clock) disable iff (reset)
      mem_resp_valid |-> (outstanding != '0));

   // Entries marked for dropping are always a subset of those in flight
   discard_bounded: assert property (@(posedge clock) disable iff (reset)
      discard <= outstanding);

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: bench-side in-order memory with adjustable latency,
// a queue-based reference model checked every cycle, and directed scenarios
// with hand-computed literal expectations.
module tb_fetch_queue;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b1;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_data = 32'h0;
   logic        inst_valid;
   logic        inst_ready = 1'b1;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;

   int n_checks = 0;
   int n_fail   = 0;
   int lat      = 1;
   int cyc      = 0;

   fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clock          (clock),
      .reset          (reset),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clock = ~clock;

   // Instruction memory contents as a function of the word address
   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: fetches in flight tagged keep/drop, plus buffered pcs
   typedef struct packed {
      logic [31:0] pc;
      logic        keep;
   } inf_t;
   typedef struct {
      int          due;
      logic [31:0] addr;
   } pend_t;

   inf_t        m_inf[$];
   logic [31:0] m_fq[$];
   logic [31:0] m_fetch_pc = RESET_PC;
   pend_t       pend[$];

   // Model step and memory behaviour at each clock edge
   always @(posedge clock) begin
      inf_t  f;
      pend_t p;
      logic  exp_rv;
      if (reset) begin
         m_fq.delete();
         m_inf.delete();
         m_fetch_pc = RESET_PC;
      end else begin
         exp_rv = !redirect_valid && (int'(m_fq.size() + m_inf.size()) < int'(DEPTH));
         if (m_fq.size() != 0 && inst_ready && !redirect_valid) void'(m_fq.pop_front());
         if (mem_resp_valid && m_inf.size() != 0) begin
            f = m_inf.pop_front();
            if (f.keep && !redirect_valid) m_fq.push_back(f.pc);
         end
         if (redirect_valid) begin
            m_fq.delete();
            foreach (m_inf[k]) m_inf[k].keep = 1'b0;
            m_fetch_pc = redirect_pc & ~32'h3;
         end else if (exp_rv && mem_req_ready) begin
            f.pc   = m_fetch_pc;
            f.keep = 1'b1;
            m_inf.push_back(f);
            m_fetch_pc = m_fetch_pc + 32'd4;
         end
      end
      if (reset) begin
         pend.delete();
      end else begin
         if (mem_resp_valid && pend.size() != 0) void'(pend.pop_front());
         if (mem_req_valid && mem_req_ready) begin
            p.due  = cyc + lat;
            if (pend.size() != 0 && pend[$].due >= p.due) p.due = pend[$].due + 1;
            p.addr = mem_req_addr;
            pend.push_back(p);
         end
      end
      cyc++;
      #1;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = memf(pend[0].addr);
      end else begin
         mem_resp_valid = 1'b0;
         mem_resp_data  = 32'h0;
      end
   end

   // Per-cycle comparison of DUT outputs against the model
   always @(negedge clock) begin
      if (!reset) begin
         chk("req_valid", 32'(mem_req_valid),
             32'(!redirect_valid && (int'(m_fq.size() + m_inf.size()) < int'(DEPTH))));
         chk("req_addr", mem_req_addr, m_fetch_pc);
         chk("inst_valid", 32'(inst_valid), 32'(m_fq.size() != 0));
         if (m_fq.size() != 0) begin
            chk("inst_pc", inst_pc, m_fq[0]);
            chk("inst_data", inst_data, memf(m_fq[0]));
         end
      end
   end

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   // Leaves the caller at the start of the first cycle out of reset
   task automatic do_reset();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      repeat (2) next_cycle();
      reset = 1'b0;
   endtask

   task automatic wait_first_pc(input string name, input logic [31:0] exp_pc);
      logic found;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clock);
         if (inst_valid) begin
            found = 1'b1;
            chk(name, inst_pc, exp_pc);
         end
         next_cycle();
      end
      chk({name, "_seen"}, 32'(found), 32'd1);
   endtask

   initial begin
      // 1: streaming with an ideal one-cycle memory
      lat = 1; mem_req_ready = 1'b1; inst_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         chk("t1_req_valid", 32'(mem_req_valid), 32'd1);
         chk("t1_req_addr", mem_req_addr, 32'(4 * i));
         chk("t1_inst_valid", 32'(inst_valid), 32'(i >= 2));
         if (i == 0) begin
            chk("t1_rst_pc", inst_pc, 32'h0);
            chk("t1_rst_data", inst_data, 32'h0);
         end
         if (i >= 2) chk("t1_inst_pc", inst_pc, 32'(4 * (i - 2)));
         next_cycle();
      end

      // 2: decode stalled fills the queue, then drains in order
      inst_ready = 1'b0;
      do_reset();
      repeat (8) next_cycle();
      @(negedge clock);
      chk("t2_full_req_valid", 32'(mem_req_valid), 32'd0);
      chk("t2_full_inst_valid", 32'(inst_valid), 32'd1);
      chk("t2_full_addr", mem_req_addr, 32'h10);
      next_cycle();
      inst_ready = 1'b1;
      for (int r = 0; r < 5; r++) begin
         @(negedge clock);
         chk("t2_drain_pc", inst_pc, 32'(4 * r));
         if (r == 0) chk("t2_r0_req_valid", 32'(mem_req_valid), 32'd0);
         if (r == 1) begin
            chk("t2_r1_req_valid", 32'(mem_req_valid), 32'd1);
            chk("t2_r1_addr", mem_req_addr, 32'h10);
         end
         next_cycle();
      end

      // 3: memory back-pressure holds the request stable
      do_reset();
      next_cycle();
      next_cycle();
      mem_req_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         @(negedge clock);
         chk("t3_stall_addr", mem_req_addr, 32'h8);
         chk("t3_stall_valid", 32'(mem_req_valid), 32'd1);
         next_cycle();
      end
      mem_req_ready = 1'b1;
      @(negedge clock);
      chk("t3_release_addr", mem_req_addr, 32'h8);
      next_cycle();
      @(negedge clock);
      chk("t3_next_addr", mem_req_addr, 32'hC);
      next_cycle();

      // 4: redirect with two fetches in flight at latency 3
      lat = 3;
      do_reset();
      repeat (7) next_cycle();
      redirect_valid = 1'b1; redirect_pc = 32'h203;
      @(negedge clock);
      chk("t4_redir_req_valid", 32'(mem_req_valid), 32'd0);
      chk("t4_redir_head_pc", inst_pc, 32'hC);
      next_cycle();
      redirect_valid = 1'b0;
      for (int j = 8; j <= 12; j++) begin
         @(negedge clock);
         if (j == 8) chk("t4_first_addr", mem_req_addr, 32'h200);
         if (j == 8) chk("t4_first_valid", 32'(mem_req_valid), 32'd1);
         if (j == 9) chk("t4_second_addr", mem_req_addr, 32'h204);
         chk("t4_inst_valid", 32'(inst_valid), 32'(j == 12));
         if (j == 12) begin
            chk("t4_inst_pc", inst_pc, 32'h200);
            chk("t4_inst_data", inst_data, memf(32'h200));
         end
         next_cycle();
      end

      // 5: redirect coincident with a response and a pop
      lat = 2;
      do_reset();
      repeat (4) next_cycle();
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      @(negedge clock);
      chk("t5_resp_present", 32'(mem_resp_valid), 32'd1);
      chk("t5_redir_req_valid", 32'(mem_req_valid), 32'd0);
      chk("t5_redir_head_pc", inst_pc, 32'h4);
      next_cycle();
      redirect_valid = 1'b0;
      for (int j = 5; j <= 8; j++) begin
         @(negedge clock);
         if (j == 5) chk("t5_first_addr", mem_req_addr, 32'h100);
         chk("t5_inst_valid", 32'(inst_valid), 32'(j == 8));
         if (j == 8) chk("t5_inst_pc", inst_pc, 32'h100);
         next_cycle();
      end
      // back-to-back redirects: the last target wins
      redirect_valid = 1'b1; redirect_pc = 32'h300;
      next_cycle();
      redirect_pc = 32'h401;
      next_cycle();
      redirect_valid = 1'b0;
      wait_first_pc("t5_b2b_pc", 32'h400);

      // 6: reset mid-stream with a full pipeline
      lat = 3; inst_ready = 1'b0;
      do_reset();
      repeat (5) next_cycle();
      @(negedge clock);
      chk("t6_pre_req_valid", 32'(mem_req_valid), 32'd0);
      chk("t6_pre_inst_valid", 32'(inst_valid), 32'd1);
      next_cycle();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      @(negedge clock);
      chk("t6_rst_req_valid", 32'(mem_req_valid), 32'd1);
      chk("t6_rst_addr", mem_req_addr, RESET_PC);
      chk("t6_rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("t6_rst_inst_pc", inst_pc, 32'h0);
      chk("t6_rst_inst_data", inst_data, 32'h0);
      next_cycle();
      inst_ready = 1'b1;
      wait_first_pc("t6_restart_pc", RESET_PC);

      // Mixed traffic: back-pressure on both sides, latency changes, redirects
      for (int n = 0; n < 400; n++) begin
         mem_req_ready = ($urandom_range(0, 3) != 0);
         inst_ready    = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 15) == 0) lat = $urandom_range(1, 4);
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_pc    = $urandom();
         next_cycle();
      end
      redirect_valid = 1'b0;
      mem_req_ready  = 1'b1;
      repeat (10) next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
